// File: rtl/code_memory.sv
// 256x8 program memory with a framed byte-stream loader (length, data, checksum).
// The processor read port returns NOP_BYTE and is held off while a load is in progress.
module code_memory #(
    parameter logic [7:0] NOP_BYTE  = 8'hFF,
    parameter logic [7:0] LOAD_BASE = 8'h00
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] memAddr,
    input  logic       memStrobe,
    output logic [7:0] memDataRead,
    input  logic       loadStart,
    input  logic       loadValid,
    input  logic [7:0] loadByte,
    output logic       loadReady,
    output logic       cpuHold,
    output logic       loadDone,
    output logic       loadOk,
    output logic       loadErr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_mem [256];
    logic [7:0] r_ptr;
    logic [7:0] r_sum;
    logic [8:0] r_cnt;
    logic       r_ok;
    logic       r_err;
    logic [7:0] r_rdata;
    logic       w_xfer;
    logic       w_wr;

    assign w_xfer = loadValid & loadReady;
    // A restart on the same edge as a data transfer drops that byte.
    assign w_wr   = (r_state == S_DATA) & w_xfer & ~loadStart;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (loadStart) begin
            w_next = S_LEN;
        end else begin
            case (r_state)
                S_IDLE: w_next = S_IDLE;
                S_LEN:  if (w_xfer) w_next = S_DATA;
                S_DATA: if (w_xfer && r_cnt == 9'd1) w_next = S_CSUM;
                S_CSUM: if (w_xfer) w_next = S_DONE;
                S_DONE: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        loadReady = 1'b0;
        cpuHold   = 1'b0;
        loadDone  = 1'b0;
        case (r_state)
            S_LEN, S_DATA, S_CSUM: begin
                loadReady = 1'b1;
                cpuHold   = 1'b1;
            end
            S_DONE: begin
                cpuHold  = 1'b1;
                loadDone = 1'b1;
            end
            default: begin
                loadReady = 1'b0;
                cpuHold   = 1'b0;
                loadDone  = 1'b0;
            end
        endcase
    end

    // Storage is deliberately outside the reset domain so a load survives reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_ptr] <= loadByte;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_ptr   <= LOAD_BASE;
            r_sum   <= 8'h00;
            r_cnt   <= 9'd0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            if (memStrobe) begin
                r_rdata <= (r_state == S_IDLE) ? r_mem[memAddr] : NOP_BYTE;
            end
            if (loadStart) begin
                r_ptr <= LOAD_BASE;
                r_sum <= 8'h00;
                r_ok  <= 1'b0;
                r_err <= 1'b0;
            end else if (w_xfer) begin
                case (r_state)
                    // A length byte of zero encodes a full 256-byte image.
                    S_LEN: r_cnt <= (loadByte == 8'h00) ? 9'd256 : {1'b0, loadByte};
                    S_DATA: begin
                        r_ptr <= r_ptr + 8'd1;
                        r_sum <= r_sum + loadByte;
                        r_cnt <= r_cnt - 9'd1;
                    end
                    S_CSUM: begin
                        r_ok  <= (loadByte == r_sum);
                        r_err <= (loadByte != r_sum);
                    end
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    assign memDataRead = r_rdata;
    assign loadOk      = r_ok;
    assign loadErr     = r_err;

endmodule

// File: tb/tb_code_memory.sv
// Bench for code_memory: framed loads, reads via a scoreboard, restart, wrap and reset cases.
module tb_code_memory;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic [7:0] memAddr = 8'h00;
    logic       memStrobe = 1'b0;
    logic       loadStart = 1'b0;
    logic       startB = 1'b0;
    logic       loadValid = 1'b0;
    logic [7:0] loadByte = 8'h00;

    logic [7:0] rd_a, rd_b;
    logic       ready_a, hold_a, done_a, ok_a, err_a;
    logic       ready_b, hold_b, done_b, ok_b, err_b;

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;

    typedef struct {
        bit         sel;
        logic [7:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t    tbl [16];
    logic [7:0] q_exp [$];
    bit         q_sel [$];

    always #5 clk = ~clk;

    code_memory u_a (
        .clk(clk), .resetN(resetN), .memAddr(memAddr), .memStrobe(memStrobe),
        .memDataRead(rd_a), .loadStart(loadStart), .loadValid(loadValid),
        .loadByte(loadByte), .loadReady(ready_a), .cpuHold(hold_a),
        .loadDone(done_a), .loadOk(ok_a), .loadErr(err_a)
    );

    code_memory #(.NOP_BYTE(8'hFF), .LOAD_BASE(8'hFE)) u_b (
        .clk(clk), .resetN(resetN), .memAddr(memAddr), .memStrobe(memStrobe),
        .memDataRead(rd_b), .loadStart(startB), .loadValid(loadValid),
        .loadByte(loadByte), .loadReady(ready_b), .cpuHold(hold_b),
        .loadDone(done_b), .loadOk(ok_b), .loadErr(err_b)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (done_a) n_done++;
    endtask

    task automatic send(input logic [7:0] b);
        loadValid = 1'b1;
        loadByte  = b;
        step();
        loadValid = 1'b0;
    endtask

    task automatic pulse_start(input bit on_b);
        if (on_b) startB = 1'b1;
        else loadStart = 1'b1;
        step();
        startB    = 1'b0;
        loadStart = 1'b0;
    endtask

    task automatic run_reads(input int lo, input int hi);
        logic [7:0] e;
        bit         s;
        for (int i = lo; i <= hi; i++) begin
            memStrobe = 1'b1;
            memAddr   = tbl[i].addr;
            q_exp.push_back(tbl[i].exp);
            q_sel.push_back(tbl[i].sel);
            step();
            e = q_exp.pop_front();
            s = q_sel.pop_front();
            chk($sformatf("read%0d", i), s ? rd_b : rd_a, e);
        end
        memStrobe = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 8'h00, 8'h31};
        tbl[1]  = '{1'b0, 8'h01, 8'h42};
        tbl[2]  = '{1'b0, 8'h02, 8'h53};
        tbl[3]  = '{1'b0, 8'h00, 8'h10};
        tbl[4]  = '{1'b0, 8'h01, 8'h20};
        tbl[5]  = '{1'b0, 8'h02, 8'h53};
        tbl[6]  = '{1'b1, 8'hFE, 8'h11};
        tbl[7]  = '{1'b1, 8'hFF, 8'h22};
        tbl[8]  = '{1'b1, 8'h00, 8'h33};
        tbl[9]  = '{1'b0, 8'h00, 8'h00};
        tbl[10] = '{1'b0, 8'h7F, 8'h7F};
        tbl[11] = '{1'b0, 8'hFF, 8'hFF};
        tbl[12] = '{1'b0, 8'h00, 8'h77};
        tbl[13] = '{1'b0, 8'h01, 8'h01};
        tbl[14] = '{1'b0, 8'h01, 8'h42};
        tbl[15] = '{1'b0, 8'h02, 8'h53};

        // Asynchronous reset, outputs checked before any clock edge
        #1 resetN = 1'b0;
        #1;
        chk("rst_rd", rd_a, 8'h00);
        chk("rst_ready", {7'd0, ready_a}, 8'd0);
        chk("rst_hold", {7'd0, hold_a}, 8'd0);
        chk("rst_done", {7'd0, done_a}, 8'd0);
        chk("rst_ok", {7'd0, ok_a}, 8'd0);
        chk("rst_err", {7'd0, err_a}, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #1 resetN = 1'b1;

        // Good load followed by reads
        n_done = 0;
        pulse_start(1'b0);
        chk("len_hold", {7'd0, hold_a}, 8'd1);
        chk("len_ready", {7'd0, ready_a}, 8'd1);
        send(8'h03);
        step();
        chk("stall_ready", {7'd0, ready_a}, 8'd1);
        send(8'h31);
        memStrobe = 1'b1;
        memAddr   = 8'h00;
        send(8'h42);
        memStrobe = 1'b0;
        chk("nop_read", rd_a, 8'hFF);
        chk("data_hold", {7'd0, hold_a}, 8'd1);
        send(8'h53);
        chk("csum_hold", {7'd0, hold_a}, 8'd1);
        send(8'hC6);
        chk("done_pulse", {7'd0, done_a}, 8'd1);
        chk("done_hold", {7'd0, hold_a}, 8'd1);
        chk("done_ready", {7'd0, ready_a}, 8'd0);
        chk("good_ok", {7'd0, ok_a}, 8'd1);
        chk("good_err", {7'd0, err_a}, 8'd0);
        step();
        chk("idle_hold", {7'd0, hold_a}, 8'd0);
        chk("idle_done", {7'd0, done_a}, 8'd0);
        chk("done_count", n_done[7:0], 8'd1);
        run_reads(14, 15);
        run_reads(0, 2);
        step();
        chk("read_hold", rd_a, 8'h53);

        // Bad checksum keeps data
        pulse_start(1'b0);
        chk("start_clr_ok", {7'd0, ok_a}, 8'd0);
        send(8'h03); send(8'h31); send(8'h42); send(8'h53); send(8'h00);
        chk("bad_err", {7'd0, err_a}, 8'd1);
        chk("bad_ok", {7'd0, ok_a}, 8'd0);
        step();
        run_reads(0, 2);

        // Restart mid-data coinciding with a transfer
        pulse_start(1'b0);
        send(8'h04); send(8'hAA); send(8'hBB);
        loadStart = 1'b1;
        loadValid = 1'b1;
        loadByte  = 8'hCC;
        step();
        loadStart = 1'b0;
        loadValid = 1'b0;
        chk("rst_clr_err", {7'd0, err_a}, 8'd0);
        chk("rst_clr_ok", {7'd0, ok_a}, 8'd0);
        chk("restart_ready", {7'd0, ready_a}, 8'd1);
        send(8'h02); send(8'h10); send(8'h20); send(8'h30);
        chk("restart_ok", {7'd0, ok_a}, 8'd1);
        step();
        run_reads(3, 5);

        // Wrap-around on the instance loading at FE
        pulse_start(1'b1);
        chk("wrap_hold", {7'd0, hold_b}, 8'd1);
        send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h66);
        chk("wrap_done", {7'd0, done_b}, 8'd1);
        chk("wrap_ok", {7'd0, ok_b}, 8'd1);
        step();
        run_reads(6, 8);

        // Length 0 means a full 256-byte image
        pulse_start(1'b0);
        send(8'h00);
        for (int i = 0; i < 256; i++) begin
            send(i[7:0]);
            if (i == 254) begin
                chk("n256_ready", {7'd0, ready_a}, 8'd1);
                chk("n256_done", {7'd0, done_a}, 8'd0);
            end
        end
        send(8'h80);
        chk("n256_ok", {7'd0, ok_a}, 8'd1);
        step();
        run_reads(9, 11);

        // Reset in the middle of a load
        pulse_start(1'b0);
        send(8'h02);
        send(8'h77);
        @(posedge clk);
        #1 resetN = 1'b0;
        #1;
        chk("mid_rst_hold", {7'd0, hold_a}, 8'd0);
        chk("mid_rst_ready", {7'd0, ready_a}, 8'd0);
        chk("mid_rst_rd", rd_a, 8'h00);
        chk("mid_rst_ok", {7'd0, ok_a}, 8'd0);
        #3 resetN = 1'b1;
        run_reads(12, 13);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
